// File: rtl/ysyx_pkg.sv
// Shared encodings and state type for the load/store unit.
// Access-type codes match the dm_rd_sel/dm_wr_sel fields driven by the execute stage.
package ysyx_pkg;

    localparam logic [2:0] RD_NONE = 3'b000;
    localparam logic [2:0] RD_LB   = 3'b001;
    localparam logic [2:0] RD_LBU  = 3'b010;
    localparam logic [2:0] RD_LH   = 3'b011;
    localparam logic [2:0] RD_LHU  = 3'b100;
    localparam logic [2:0] RD_LW   = 3'b101;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_SB   = 2'b01;
    localparam logic [1:0] WR_SH   = 2'b10;
    localparam logic [1:0] WR_SW   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MREQ,
        S_MWAIT,
        S_RESP
    } lsu_state_e;

    function automatic logic is_load(input logic [2:0] rd_sel);
        return (rd_sel >= RD_LB) && (rd_sel <= RD_LW);
    endfunction

    // A store takes priority, so only its size matters when both fields are set.
    function automatic logic misaligned(input logic [1:0] off, input logic [2:0] rd_sel,
                                        input logic [1:0] wr_sel);
        if (wr_sel != WR_NONE)
            return ((wr_sel == WR_SH) && off[0]) || ((wr_sel == WR_SW) && (off != 2'b00));
        return (((rd_sel == RD_LH) || (rd_sel == RD_LHU)) && off[0]) ||
               ((rd_sel == RD_LW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational lane steering: store strobes, store data replication and load extension.
// Offsets are aligned down to the access size, so misaligned halfwords/words use the containing lane.
module ysyx_lsu_align
    import ysyx_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  rd_sel_i,
    input  logic [1:0]  wr_sel_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [1:0]  ld_off;
    logic [31:0] lane;

    always_comb begin
        wstrb_o = '0;
        wdata_o = wdata_i;
        case (wr_sel_i)
            WR_SB: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            WR_SH: begin
                wstrb_o = 4'b0011 << {off_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            WR_SW:   wstrb_o = 4'b1111;
            default: wstrb_o = '0;
        endcase
    end

    always_comb begin
        case (rd_sel_i)
            RD_LB, RD_LBU: ld_off = off_i;
            RD_LH, RD_LHU: ld_off = {off_i[1], 1'b0};
            default:       ld_off = 2'b00;
        endcase
        lane   = mem_rdata_i >> {ld_off, 3'b000};
        load_o = '0;
        case (rd_sel_i)
            RD_LB:   load_o = {{24{lane[7]}}, lane[7:0]};
            RD_LBU:  load_o = {24'd0, lane[7:0]};
            RD_LH:   load_o = {{16{lane[15]}}, lane[15:0]};
            RD_LHU:  load_o = {16'd0, lane[15:0]};
            RD_LW:   load_o = lane;
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one request in flight, IDLE -> MREQ -> MWAIT -> RESP.
// Define YSYX_LSU_MISALIGN_CHK_EN to fault misaligned halfword/word accesses instead of aligning them down.
module ysyx_lsu
    import ysyx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_rd_sel,
    input  logic [1:0]  dm_wr_sel,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  rd_sel_q, rd_sel_d;
    logic [1:0]  wr_sel_q, wr_sel_d;
    logic        err_q, err_d;

    logic        req_store, req_load, req_mis;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_load;

    assign req_store = (dm_wr_sel != WR_NONE);
    assign req_load  = !req_store && is_load(dm_rd_sel);
`ifdef YSYX_LSU_MISALIGN_CHK_EN
    assign req_mis   = misaligned(addr[1:0], dm_rd_sel, dm_wr_sel);
`else
    assign req_mis   = 1'b0;
`endif

    ysyx_lsu_align u_align (
        .off_i       (addr_q[1:0]),
        .rd_sel_i    (rd_sel_q),
        .wr_sel_i    (wr_sel_q),
        .wdata_i     (wdata_q),
        .mem_rdata_i (mem_rdata),
        .wstrb_o     (al_wstrb),
        .wdata_o     (al_wdata),
        .load_o      (al_load)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_sel_d = rd_sel_q;
        wr_sel_d = wr_sel_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = addr;
                    wdata_d  = wdata;
                    rd_sel_d = dm_rd_sel;
                    wr_sel_d = dm_wr_sel;
                    rdata_d  = '0;
                    err_d    = req_mis;
                    state_d  = ((req_store || req_load) && !req_mis) ? S_MREQ : S_RESP;
                end
            end
            S_MREQ:  if (mem_req_ready) state_d = S_MWAIT;
            S_MWAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = (wr_sel_q != WR_NONE) ? '0 : al_load;
                    state_d = S_RESP;
                end
            end
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_sel_q <= RD_NONE;
            wr_sel_q <= WR_NONE;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_sel_q <= rd_sel_d;
            wr_sel_q <= wr_sel_d;
            err_q    <= err_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_RESP);
    assign mem_req_valid = (state_q == S_MREQ);
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_wen       = (state_q == S_MREQ) && (wr_sel_q != WR_NONE);
    assign mem_wstrb     = (state_q == S_MREQ) ? al_wstrb : '0;
    assign mem_wdata     = al_wdata;
    assign rdata         = rdata_q;
    assign resp_err      = err_q;

endmodule
